// File: rtl/atd_shift_ctrl.sv
// -----------------------------------------------------------------------------
// atd_shift_ctrl
//   Upstream control stage for the ATD serial-to-parallel shift register.
//   Qualifies raw serial bits, emits a registered one-cycle shift strobe plus
//   data bit for the shift register, counts the shifts of a frame and raises
//   block_ready once the parallel word is complete. block_ready holds until
//   the downstream consumer acknowledges it.
//
// Ports
//   clk               in   1      system clock, rising edge
//   rst               in   1      synchronous active-high reset
//   frame_start       in   1      begin a new frame (aborts one in flight)
//   serial_valid      in   1      serial_in carries a valid bit this cycle
//   serial_in         in   1      raw serial data bit
//   block_ack         in   1      downstream consumed the parallel word
//   ATD_shift_enable  out  1      registered one-cycle shift strobe
//   ATD_data          out  1      registered serial bit for the shift register
//   block_ready       out  1      parallel word complete and stable
//   bit_count         out  CNT_W  shifts accepted in the current frame
//   overrun_err       out  1      sticky: bit arrived while block_ready high
// -----------------------------------------------------------------------------
module atd_shift_ctrl #(
  parameter  int NUM_BITS = 128,
  localparam int CNT_W    = $clog2(NUM_BITS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             serial_valid,
  input  logic             serial_in,
  input  logic             block_ack,
  output logic             ATD_shift_enable,
  output logic             ATD_data,
  output logic             block_ready,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    READY = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;

  logic             shift_en_next;
  logic             data_next;
  logic [CNT_W-1:0] count_next;
  logic             overrun_next;

  logic             accept;
  logic             last_bit;

  // A bit is only taken while shifting; a restart in the same cycle still
  // takes the bit, but as bit 1 of the new frame, so it can never be last.
  assign accept   = (state == SHIFT) && serial_valid;
  assign last_bit = accept && !frame_start &&
                    (bit_count == CNT_W'(NUM_BITS - 1));

  // block_ready is a pure decode of the state register, so it rises on the
  // same edge the shift register captures its final bit.
  assign block_ready = (state == READY);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      ATD_shift_enable <= 1'b0;
      ATD_data         <= 1'b0;
      bit_count        <= '0;
      overrun_err      <= 1'b0;
    end else begin
      state            <= state_next;
      ATD_shift_enable <= shift_en_next;
      ATD_data         <= data_next;
      bit_count        <= count_next;
      overrun_err      <= overrun_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = SHIFT;
      SHIFT:   if (last_bit)    state_next = FLUSH;
      FLUSH:   state_next = READY;
      READY: begin
        // Without an ack the completed word is protected, so a lone
        // frame_start is ignored here.
        if (block_ack) state_next = frame_start ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    shift_en_next = accept;
    data_next     = accept ? serial_in : ATD_data;
    count_next    = bit_count;
    overrun_next  = overrun_err | (block_ready & serial_valid);

    case (state)
      IDLE: begin
        if (frame_start) count_next = '0;
      end
      SHIFT: begin
        if (frame_start) begin
          count_next = accept ? CNT_W'(1) : '0;
        end else if (accept && (bit_count < CNT_W'(NUM_BITS))) begin
          count_next = bit_count + CNT_W'(1);
        end
      end
      READY: begin
        if (block_ack) count_next = '0;
      end
      default: begin
        count_next = bit_count;
      end
    endcase
  end

endmodule

// File: tb/tb_atd_shift_ctrl.sv
// -----------------------------------------------------------------------------
// tb_atd_shift_ctrl
//   Self-checking bench for atd_shift_ctrl: a directed vector table, directed
//   multi-cycle sequences and a randomized soak, all compared every cycle
//   against a behavioural frame model kept in the bench.
// -----------------------------------------------------------------------------
module tb_atd_shift_ctrl;

  localparam int NB = 128;
  localparam int CW = $clog2(NB) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          serial_valid = 1'b0;
  logic          serial_in = 1'b0;
  logic          block_ack = 1'b0;
  logic          ATD_shift_enable;
  logic          ATD_data;
  logic          block_ready;
  logic [CW-1:0] bit_count;
  logic          overrun_err;

  atd_shift_ctrl #(.NUM_BITS(NB)) dut (
    .clk              (clk),
    .rst              (rst),
    .frame_start      (frame_start),
    .serial_valid     (serial_valid),
    .serial_in        (serial_in),
    .block_ack        (block_ack),
    .ATD_shift_enable (ATD_shift_enable),
    .ATD_data         (ATD_data),
    .block_ready      (block_ready),
    .bit_count        (bit_count),
    .overrun_err      (overrun_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  // Behavioural frame model: a frame is "in progress", "just completed"
  // (word capturing) or "held" until acknowledged.
  logic    m_active, m_flush, m_ready, m_strobe, m_data, m_overrun;
  int      m_count;

  // Shift register rebuilt from the DUT strobes, plus strobe counter.
  logic [NB-1:0] tb_sr = '0;
  int            strobes = 0;

  typedef struct {
    logic r, fs, sv, si, ack;
    logic en, d, rdy;
    int   cnt;
    logic ovr;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input int actual, input int expected);
    nvec++;
    if (actual !== expected) begin
      nmis++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkWord(input string name, input logic [NB-1:0] actual, input logic [NB-1:0] expected);
    nvec++;
    if (actual !== expected) begin
      nmis++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic stepModel(input logic r, input logic fs, input logic sv, input logic si, input logic ack);
    if (r) begin
      m_active = 0; m_flush = 0; m_ready = 0; m_strobe = 0;
      m_data = 0; m_overrun = 0; m_count = 0;
      return;
    end
    m_strobe = 0;
    if (m_ready) begin
      if (sv) m_overrun = 1;
      if (ack) begin
        m_ready  = 0;
        m_count  = 0;
        m_active = fs;
      end
    end else if (m_flush) begin
      m_flush = 0;
      m_ready = 1;
    end else if (m_active) begin
      if (fs)      m_count = sv ? 1 : 0;
      else if (sv) m_count = m_count + 1;
      if (sv) begin
        m_strobe = 1;
        m_data   = si;
      end
      if (!fs && sv && m_count == NB) begin
        m_active = 0;
        m_flush  = 1;
      end
    end else if (fs) begin
      m_active = 1;
      m_count  = 0;
    end
  endtask

  // Drive one cycle of inputs, step the model across the edge and compare.
  task automatic applyStimulus(input logic r, input logic fs, input logic sv, input logic si, input logic ack);
    rst = r; frame_start = fs; serial_valid = sv; serial_in = si; block_ack = ack;
    @(posedge clk);
    #1;
    stepModel(r, fs, sv, si, ack);
    if (ATD_shift_enable) begin
      tb_sr = {tb_sr[NB-2:0], ATD_data};
      strobes++;
    end
    checkOutput("shift_enable", int'(ATD_shift_enable), int'(m_strobe));
    checkOutput("data", int'(ATD_data), int'(m_data));
    checkOutput("block_ready", int'(block_ready), int'(m_ready));
    checkOutput("bit_count", int'(bit_count), m_count);
    checkOutput("overrun_err", int'(overrun_err), int'(m_overrun));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [7:0]    a5;
    logic [NB-1:0] exp_word;
    int            s0;

    a5 = 8'hA5;
    stepModel(1, 0, 0, 0, 0);

    //            r  fs sv si ack  en d  rdy cnt ovr
    vecs[0]  = '{1, 0, 0, 0, 0,   0, 0, 0,  0,  0};
    vecs[1]  = '{1, 0, 0, 0, 0,   0, 0, 0,  0,  0};
    vecs[2]  = '{0, 1, 0, 0, 0,   0, 0, 0,  0,  0};
    vecs[3]  = '{0, 0, 1, 1, 0,   1, 1, 0,  1,  0};
    vecs[4]  = '{0, 0, 1, 0, 0,   1, 0, 0,  2,  0};
    vecs[5]  = '{0, 0, 0, 0, 0,   0, 0, 0,  2,  0};
    vecs[6]  = '{0, 0, 1, 1, 0,   1, 1, 0,  3,  0};
    vecs[7]  = '{0, 1, 1, 0, 0,   1, 0, 0,  1,  0};
    vecs[8]  = '{0, 1, 0, 0, 0,   0, 0, 0,  0,  0};
    vecs[9]  = '{0, 0, 1, 1, 0,   1, 1, 0,  1,  0};
    vecs[10] = '{1, 0, 1, 1, 0,   0, 0, 0,  0,  0};
    vecs[11] = '{0, 0, 1, 1, 0,   0, 0, 0,  0,  0};
    vecs[12] = '{0, 1, 1, 1, 0,   0, 0, 0,  0,  0};
    vecs[13] = '{0, 0, 1, 1, 0,   1, 1, 0,  1,  0};

    $display("[TB] vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].fs, vecs[i].sv, vecs[i].si, vecs[i].ack);
      checkOutput("tbl_en", int'(ATD_shift_enable), int'(vecs[i].en));
      checkOutput("tbl_data", int'(ATD_data), int'(vecs[i].d));
      checkOutput("tbl_ready", int'(block_ready), int'(vecs[i].rdy));
      checkOutput("tbl_count", int'(bit_count), vecs[i].cnt);
      checkOutput("tbl_overrun", int'(overrun_err), int'(vecs[i].ovr));
    end

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, i[0], 0);
    applyStimulus(1, 0, 1, 1, 0);
    applyStimulus(1, 0, 1, 1, 0);
    checkOutput("rst_en", int'(ATD_shift_enable), 0);
    checkOutput("rst_count", int'(bit_count), 0);
    checkOutput("rst_ready", int'(block_ready), 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("rst_idle_ignores_valid", int'(ATD_shift_enable), 0);

    $display("[TB] full frame of 0xA5 bits");
    applyStimulus(0, 1, 0, 0, 0);
    s0 = strobes;
    for (int i = 0; i < NB; i++) applyStimulus(0, 0, 1, a5[7 - (i % 8)], 0);
    checkOutput("full_last_strobe", int'(ATD_shift_enable), 1);
    checkOutput("full_ready_after_1", int'(block_ready), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("full_ready_after_2", int'(block_ready), 1);
    checkOutput("full_strobes", strobes - s0, NB);
    checkWord("full_sr_word", tb_sr, {16{8'hA5}});
    checkOutput("full_count", int'(bit_count), NB);

    $display("[TB] overrun during ready");
    s0 = strobes;
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 1, 0);
    checkOutput("ovr_no_strobes", strobes - s0, 0);
    checkOutput("ovr_flag", int'(overrun_err), 1);
    checkWord("ovr_word_kept", tb_sr, {16{8'hA5}});
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("ovr_start_ignored", int'(block_ready), 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("ovr_ack_ready", int'(block_ready), 0);
    checkOutput("ovr_ack_count", int'(bit_count), 0);
    checkOutput("ovr_sticky", int'(overrun_err), 1);

    $display("[TB] gapped random frame");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    s0 = strobes;
    exp_word = '0;
    for (int i = 0; i < NB; i++) begin
      logic b;
      b = 1'($urandom);
      exp_word = {exp_word[NB-2:0], b};
      idleCycles(int'($urandom_range(0, 3)));
      applyStimulus(0, 0, 1, b, 0);
      checkOutput("gap_count", int'(bit_count), i + 1);
    end
    checkOutput("gap_ready_after_1", int'(block_ready), 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("gap_ready_after_2", int'(block_ready), 1);
    checkOutput("gap_strobes", strobes - s0, NB);
    checkWord("gap_sr_word", tb_sr, exp_word);

    $display("[TB] ack and start in the same cycle");
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("ackst_ready", int'(block_ready), 0);
    checkOutput("ackst_count", int'(bit_count), 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("ackst_strobe", int'(ATD_shift_enable), 1);
    checkOutput("ackst_count1", int'(bit_count), 1);

    $display("[TB] restart at bit 60");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    for (int i = 0; i < 59; i++) applyStimulus(0, 0, 1, 1'($urandom), 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("restart_count0", int'(bit_count), 0);
    for (int i = 0; i < NB - 1; i++) applyStimulus(0, 0, 1, 1'($urandom), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("restart_not_ready", int'(block_ready), 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("restart_ready", int'(block_ready), 1);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] random soak");
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 399) == 0),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      if (!m_active && !m_flush && !m_ready && $urandom_range(0, 3) == 0)
        applyStimulus(0, 1, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
